// File: rtl/handwrite_canvas.sv
// handwrite_canvas: pen samples to a 30x30 bitmap with a submit/wait/clear handshake.
// Define THICK_BRUSH_EN to paint a clipped 3x3 neighbourhood per sample instead of one cell.
module handwrite_canvas #(
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter int CELL_SHIFT = 4,
  parameter int TIMEOUT = 1023,
  parameter int AUTO_CLEAR = 1
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_pen_valid,
  input  logic         i_pen_down,
  input  logic [9:0]   i_pen_x,
  input  logic [9:0]   i_pen_y,
  input  logic         i_key_submit,
  input  logic         i_key_clear,
  input  logic         i_result_valid,
  output logic [899:0] o_handwrite,
  output logic         o_button_pressed,
  output logic         o_busy,
  output logic [9:0]   o_ink_count
);
  localparam logic [1:0] DRAW = 2'd0, SUBMIT = 2'd1, WAIT = 2'd2, CLEAR = 2'd3;
  logic [1:0]   state_q, state_d;
  logic         sub_q, sub_d, clr_q, clr_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [4:0]   row_q, row_d;
  logic         s1_vld_q, s1_vld_d;
  logic [4:0]   cx_q, cx_d, cy_q, cy_d;
  logic [899:0] bm_q, bm_d;
  logic [9:0]   ink_q, ink_d;
  logic [10:0]  dx, dy;
  logic [9:0]   cx_w, cy_w, inc;
  logic [899:0] mask, fresh;
  logic         sub_rise, clr_rise, done;
  // bit 10 of the 11-bit difference flags a sample left of / above the canvas
  always_comb begin
    dx = {1'b0, i_pen_x} - 11'(X0);
    dy = {1'b0, i_pen_y} - 11'(Y0);
    cx_w = dx[9:0] >> CELL_SHIFT;
    cy_w = dy[9:0] >> CELL_SHIFT;
    s1_vld_d = i_pen_valid & i_pen_down & ~dx[10] & ~dy[10] & (cx_w < 10'd30) & (cy_w < 10'd30) & (state_q == DRAW);
    cx_d = cx_w[4:0];
    cy_d = cy_w[4:0];
  end
  always_comb begin
    mask = '0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++)
`ifdef THICK_BRUSH_EN
        mask[r*30+c] = (r + 1 >= int'(cy_q)) && (r <= int'(cy_q) + 1) && (c + 1 >= int'(cx_q)) && (c <= int'(cx_q) + 1);
`else
        mask[r*30+c] = (r == int'(cy_q)) && (c == int'(cx_q));
`endif
    fresh = (s1_vld_q && state_q != CLEAR) ? mask & ~bm_q : '0;
    inc = '0;
    for (int i = 0; i < 900; i++) inc = inc + {9'd0, fresh[i]};
  end
  always_comb begin
    sub_d = i_key_submit;
    clr_d = i_key_clear;
    sub_rise = i_key_submit & ~sub_q;
    clr_rise = i_key_clear & ~clr_q;
    done = i_result_valid || cnt_q == 16'(TIMEOUT);
    state_d = state_q == DRAW   ? (clr_rise ? CLEAR : (sub_rise && ink_q != 10'd0) ? SUBMIT : DRAW) :
              state_q == SUBMIT ? WAIT :
              state_q == WAIT   ? (done ? (AUTO_CLEAR != 0 ? CLEAR : DRAW) : WAIT) :
              (row_q == 5'd29 ? DRAW : CLEAR);
    cnt_d = state_q == WAIT ? cnt_q + 16'd1 : '0;
    row_d = (state_q == CLEAR && row_q != 5'd29) ? row_q + 5'd1 : '0;
    ink_d = state_d == CLEAR ? '0 : ink_q + inc;
    bm_d = bm_q | fresh;
    if (state_q == CLEAR)
      for (int r = 0; r < 30; r++)
        if (row_q == 5'(r)) bm_d[r*30 +: 30] = '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= DRAW;
      sub_q    <= 1'b0;
      clr_q    <= 1'b0;
      cnt_q    <= '0;
      row_q    <= '0;
      s1_vld_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      bm_q     <= '0;
      ink_q    <= '0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      clr_q    <= clr_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      s1_vld_q <= s1_vld_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      bm_q     <= bm_d;
      ink_q    <= ink_d;
    end
  end
  assign o_handwrite = bm_q;
  assign o_button_pressed = state_q == SUBMIT;
  assign o_busy = state_q != DRAW;
  assign o_ink_count = ink_q;
endmodule

// File: tb/tb_handwrite_canvas.sv
// tb_handwrite_canvas: directed scoreboard bench; instance a uses defaults, b has AUTO_CLEAR=0, TIMEOUT=20.
module tb_handwrite_canvas;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pen_valid = 1'b0, pen_down = 1'b0, key_submit = 1'b0, key_clear = 1'b0, result_valid = 1'b0;
  logic [9:0] pen_x = '0, pen_y = '0;
  logic [899:0] hw_a, hw_b;
  logic bp_a, bp_b, busy_a, busy_b;
  logic [9:0] ink_a, ink_b;
  typedef struct {
    string tag;
    logic [899:0] bm;
    logic [9:0] ink;
  } exp_t;
  exp_t sb[$];
  logic [899:0] exp_bm = '0;
  int exp_ink = 0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  handwrite_canvas u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pen_valid(pen_valid), .i_pen_down(pen_down),
    .i_pen_x(pen_x), .i_pen_y(pen_y), .i_key_submit(key_submit), .i_key_clear(key_clear),
    .i_result_valid(result_valid), .o_handwrite(hw_a), .o_button_pressed(bp_a),
    .o_busy(busy_a), .o_ink_count(ink_a)
  );
  handwrite_canvas #(.TIMEOUT(20), .AUTO_CLEAR(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pen_valid(pen_valid), .i_pen_down(pen_down),
    .i_pen_x(pen_x), .i_pen_y(pen_y), .i_key_submit(key_submit), .i_key_clear(key_clear),
    .i_result_valid(result_valid), .o_handwrite(hw_b), .o_button_pressed(bp_b),
    .o_busy(busy_b), .o_ink_count(ink_b)
  );

  function automatic logic [899:0] brush(input int cx, input int cy);
    logic [899:0] m;
    m = '0;
`ifdef THICK_BRUSH_EN
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (cy + dr >= 0 && cy + dr < 30 && cx + dc >= 0 && cx + dc < 30) m[(cy+dr)*30 + cx + dc] = 1'b1;
`else
    m[cy*30 + cx] = 1'b1;
`endif
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bm(input string tag, input logic [899:0] obs, input logic [899:0] exp);
    int r;
    r = 0;
    for (int i = 29; i >= 0; i--) if (obs[i*30 +: 30] !== exp[i*30 +: 30]) r = i;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: row %0d got %h expected %h", tag, r, obs[r*30 +: 30], exp[r*30 +: 30]);
    end
  endtask

  task automatic pen(input string tag, input int x, input int y, input logic d);
    exp_t e;
    logic [899:0] prev;
    prev = exp_bm;
    pen_x = 10'(x);
    pen_y = 10'(y);
    pen_down = d;
    pen_valid = 1'b1;
    if (d && x < 480 && y < 480) exp_bm = exp_bm | brush(x / 16, y / 16);
    exp_ink = $countones(exp_bm);
    e.tag = tag;
    e.bm = exp_bm;
    e.ink = 10'(exp_ink);
    sb.push_back(e);
    @(negedge clk);
    pen_valid = 1'b0;
    pen_down = 1'b0;
    chk_bm({tag, "_lat"}, hw_a, prev);
    @(negedge clk);
    e = sb.pop_front();
    chk_bm(e.tag, hw_a, e.bm);
    chk({e.tag, "_ink"}, 32'(ink_a), 32'(e.ink));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_bm = '0;
    exp_ink = 0;
  endtask

  initial begin
    @(negedge clk);
    chk_bm("rst_bm", hw_a, '0);
    chk("rst_ink", 32'(ink_a), 0);
    chk("rst_bp", 32'(bp_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    rst_n = 1'b1;
    pen("p35_20", 35, 20, 1'b1);
    pen("p35_20_again", 35, 20, 1'b1);
    pen("p479", 479, 479, 1'b1);
    pen("p480_0", 480, 0, 1'b1);
    pen("p5_500", 5, 500, 1'b1);
    pen("pen_up", 200, 200, 1'b0);
    // submit handshake, cycle N = this negedge
    key_submit = 1'b1;
    @(negedge clk);
    chk("sub_bp_n1", 32'(bp_a), 1);
    chk("sub_busy_n1", 32'(busy_a), 1);
    key_submit = 1'b0;
    @(negedge clk);
    chk("sub_bp_n2", 32'(bp_a), 0);
    @(negedge clk);
    pen_x = 10'd100;
    pen_y = 10'd100;
    pen_down = 1'b1;
    pen_valid = 1'b1;
    @(negedge clk);
    pen_valid = 1'b0;
    pen_down = 1'b0;
    repeat (901) @(negedge clk);
    chk_bm("wait_frozen", hw_a, exp_bm);
    chk("wait_busy", 32'(busy_a), 1);
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    chk("clr_busy_first", 32'(busy_a), 1);
    chk("clr_ink_zero", 32'(ink_a), 0);
    repeat (29) @(negedge clk);
    chk("clr_busy_last", 32'(busy_a), 1);
    @(negedge clk);
    chk("clr_done_busy", 32'(busy_a), 0);
    chk_bm("clr_done_bm", hw_a, '0);
    chk("clr_done_ink", 32'(ink_a), 0);
    exp_bm = '0;
    exp_ink = 0;
    // empty submit is ignored
    key_submit = 1'b1;
    @(negedge clk);
    chk("empty_bp", 32'(bp_a), 0);
    chk("empty_busy", 32'(busy_a), 0);
    key_submit = 1'b0;
    for (int i = 0; i < 5; i++) pen($sformatf("row0_%0d", i), i * 16, 0, 1'b1);
    key_submit = 1'b1;
    key_clear = 1'b1;
    @(negedge clk);
    chk("both_bp", 32'(bp_a), 0);
    chk("both_busy", 32'(busy_a), 1);
    chk("both_ink", 32'(ink_a), 0);
    key_submit = 1'b0;
    key_clear = 1'b0;
    repeat (30) @(negedge clk);
    chk("both_done_busy", 32'(busy_a), 0);
    chk_bm("both_done_bm", hw_a, '0);
    // timeout without auto-clear on instance b, submit held high
    do_reset();
    pen("b_draw", 35, 20, 1'b1);
    chk("b_ink", 32'(ink_b), 32'(exp_ink));
    key_submit = 1'b1;
    @(negedge clk);
    chk("b_bp", 32'(bp_b), 1);
    repeat (21) @(negedge clk);
    chk("b_busy_at_timeout", 32'(busy_b), 1);
    @(negedge clk);
    chk("b_busy_after", 32'(busy_b), 0);
    chk_bm("b_bm_kept", hw_b, exp_bm);
    chk("b_ink_kept", 32'(ink_b), 32'(exp_ink));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("b_no_repulse_%0d", i), 32'(bp_b), 0);
    end
    key_submit = 1'b0;
    // brush footprint, then reset mid-WAIT
    do_reset();
    pen("cell00", 0, 0, 1'b1);
    pen("cell55", 80, 80, 1'b1);
    key_submit = 1'b1;
    repeat (10) @(negedge clk);
    key_submit = 1'b0;
    chk("midwait_busy", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk_bm("arst_bm", hw_a, '0);
    chk("arst_ink", 32'(ink_a), 0);
    chk("arst_bp", 32'(bp_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy_a), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
